// File: rtl/usb_fs_rx_frontend_if.sv
// Receive-side output bundle of the FS USB front end: activity level, byte strobe/data,
// error and end-of-packet strobes. master = front end, slave = packet decoder.
interface usb_fs_rx_frontend_if;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       eop;

  modport master (output rx_active, rx_valid, rx_data, rx_error, eop);
  modport slave  (input  rx_active, rx_valid, rx_data, rx_error, eop);
endinterface

// File: rtl/usb_fs_rx_frontend.sv
// Full-speed USB receive front end: pad synchronisers, bit-timing recovery, NRZI decode,
// SYNC detection, bit un-stuffing, EOP detection and LSB-first byte assembly.
module usb_fs_rx_frontend #(
  parameter int OVERSAMPLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 dp_i,
  input  logic                 dm_i,
  usb_fs_rx_frontend_if.master rx_o
);
  localparam int            PW        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PW-1:0] PH_SAMPLE = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_LAST   = PW'(OVERSAMPLE - 1);
  localparam logic [1:0]    LS_J      = 2'b10;
  localparam logic [1:0]    LS_K      = 2'b01;
  localparam logic [1:0]    LS_SE0    = 2'b00;
  localparam logic [1:0]    LS_SE1    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_EOP1, S_EOP2, S_ERR
  } state_t;

  logic          dp_meta_q, dp_sync_q, dm_meta_q, dm_sync_q;
  logic [1:0]    line_q;
  logic [1:0]    prev_q, prev_d;
  logic [PW-1:0] phase_q, phase_d;
  state_t        state_q, state_d;
  logic [2:0]    zero_cnt_q, zero_cnt_d;
  logic [2:0]    ones_cnt_q, ones_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sreg_q, sreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic          eop_q, eop_d;
  logic          active_q, active_d;
  logic          err_se0_q, err_se0_d;

  logic [1:0]    line;
  logic          sample;
  logic          is_j, is_k, is_se0, is_se1;
  logic          bit_dec;
  logic          stuff_slot;
  logic [7:0]    byte_nxt;

  assign line       = {dp_sync_q, dm_sync_q};
  assign sample     = (phase_q == PH_SAMPLE);
  assign is_j       = (line == LS_J);
  assign is_k       = (line == LS_K);
  assign is_se0     = (line == LS_SE0);
  assign is_se1     = (line == LS_SE1);
  assign bit_dec    = (line == prev_q);
  assign stuff_slot = (ones_cnt_q == 3'd6);
  assign byte_nxt   = {bit_dec, sreg_q[7:1]};

  // Every line edge re-centres the sample point half a bit later.
  assign phase_d = (line != line_q)     ? PW'(1) :
                   (phase_q == PH_LAST) ? '0     : phase_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_meta_q  <= 1'b1;
      dp_sync_q  <= 1'b1;
      dm_meta_q  <= 1'b0;
      dm_sync_q  <= 1'b0;
      line_q     <= LS_J;
      prev_q     <= LS_J;
      phase_q    <= '0;
      state_q    <= S_IDLE;
      zero_cnt_q <= '0;
      ones_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sreg_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      eop_q      <= 1'b0;
      active_q   <= 1'b0;
      err_se0_q  <= 1'b0;
    end else begin
      dp_meta_q  <= dp_i;
      dp_sync_q  <= dp_meta_q;
      dm_meta_q  <= dm_i;
      dm_sync_q  <= dm_meta_q;
      line_q     <= line;
      prev_q     <= prev_d;
      phase_q    <= phase_d;
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sreg_q     <= sreg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      eop_q      <= eop_d;
      active_q   <= active_d;
      err_se0_q  <= err_se0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (sample) begin
      case (state_q)
        S_IDLE: if (is_k) state_d = S_SYNC;
        S_SYNC: begin
          if (is_se0 || is_se1)  state_d = S_IDLE;
          else if (bit_dec)      state_d = (zero_cnt_q >= 3'd3) ? S_DATA : S_IDLE;
        end
        S_DATA: begin
          if (is_se0)                   state_d = S_EOP1;
          else if (is_se1)              state_d = S_ERR;
          else if (stuff_slot && bit_dec) state_d = S_ERR;
        end
        S_EOP1: state_d = is_se0 ? S_EOP2 : S_ERR;
        S_EOP2: begin
          if (is_j)         state_d = S_IDLE;
          else if (!is_se0) state_d = S_ERR;
        end
        S_ERR:  if (err_se0_q && is_j) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    prev_d     = prev_q;
    zero_cnt_d = zero_cnt_q;
    ones_cnt_d = ones_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sreg_d     = sreg_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    eop_d      = 1'b0;
    active_d   = active_q;
    err_se0_d  = err_se0_q;
    if (!enable) begin
      prev_d     = LS_J;
      zero_cnt_d = '0;
      ones_cnt_d = '0;
      bit_cnt_d  = '0;
      sreg_d     = '0;
      active_d   = 1'b0;
      err_se0_d  = 1'b0;
    end else if (sample) begin
      prev_d = line;
      case (state_q)
        S_IDLE: if (is_k) zero_cnt_d = '0;
        S_SYNC: begin
          if (is_j || is_k) begin
            if (!bit_dec) begin
              zero_cnt_d = (zero_cnt_q == 3'd7) ? 3'd7 : zero_cnt_q + 3'd1;
            end else if (zero_cnt_q >= 3'd3) begin
              active_d   = 1'b1;
              ones_cnt_d = '0;
              bit_cnt_d  = '0;
              sreg_d     = '0;
            end
          end
        end
        S_DATA: begin
          if (is_se0) begin
            // A partial byte at EOP is dropped; the EOP itself may still complete.
            error_d    = (bit_cnt_q != 3'd0);
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
          end else if (is_se1) begin
            error_d  = 1'b1;
            active_d = 1'b0;
          end else if (stuff_slot) begin
            if (bit_dec) begin
              error_d  = 1'b1;
              active_d = 1'b0;
            end else begin
              ones_cnt_d = '0;
            end
          end else begin
            sreg_d     = byte_nxt;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            ones_cnt_d = bit_dec ? ones_cnt_q + 3'd1 : 3'd0;
            if (bit_cnt_q == 3'd7) begin
              data_d  = byte_nxt;
              valid_d = 1'b1;
            end
          end
        end
        S_EOP1: begin
          if (!is_se0) begin
            error_d  = 1'b1;
            active_d = 1'b0;
          end
        end
        S_EOP2: begin
          if (is_j) begin
            eop_d    = 1'b1;
            active_d = 1'b0;
          end else if (!is_se0) begin
            error_d  = 1'b1;
            active_d = 1'b0;
          end
        end
        S_ERR: begin
          active_d  = 1'b0;
          err_se0_d = is_se0;
        end
        default: active_d = 1'b0;
      endcase
    end
  end

  assign rx_o.rx_active = active_q;
  assign rx_o.rx_valid  = valid_q;
  assign rx_o.rx_data   = data_q;
  assign rx_o.rx_error  = error_q;
  assign rx_o.eop       = eop_q;
endmodule

// File: tb/tb_usb_fs_rx_frontend.sv
// Directed FS USB packets driven at 4x oversampling; a monitor scores every strobe and
// rx_active edge against a queue of hand-computed expected events.
`timescale 1ns/1ps
module tb_usb_fs_rx_frontend;
  localparam int         OS      = 4;
  localparam logic [1:0] J       = 2'b10;
  localparam logic [1:0] K       = 2'b01;
  localparam logic [1:0] SE0     = 2'b00;
  localparam logic [2:0] EV_RISE = 3'd0;
  localparam logic [2:0] EV_BYTE = 3'd1;
  localparam logic [2:0] EV_ERR  = 3'd2;
  localparam logic [2:0] EV_EOP  = 3'd3;
  localparam logic [2:0] EV_FALL = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] dat;
  } ev_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;
  logic dp     = 1'b1;
  logic dm     = 1'b0;

  usb_fs_rx_frontend_if rx_if ();

  usb_fs_rx_frontend #(.OVERSAMPLE(OS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .dp_i   (dp),
    .dm_i   (dm),
    .rx_o   (rx_if)
  );

  always #5 clk = ~clk;

  ev_t        exp_q[$];
  logic [1:0] lv[$];
  logic [1:0] cur;
  int         ones;
  int         checks = 0;
  int         errors = 0;
  int         mark;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic [7:0] dat);
    ev_t e;
    e.kind = kind;
    e.dat  = dat;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input logic [2:0] kind, input logic [7:0] dat);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind %0d data 0x%02h, expected no event", kind, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_BYTE && e.dat != dat)) begin
        errors++;
        $display("FAIL event: got kind %0d data 0x%02h, expected kind %0d data 0x%02h",
                 kind, dat, e.kind, e.dat);
      end
    end
  endtask

  task automatic monitor();
    logic act_prev;
    act_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_if.rx_active && !act_prev) got_ev(EV_RISE, 8'h00);
      if (rx_if.rx_valid)               got_ev(EV_BYTE, rx_if.rx_data);
      if (rx_if.rx_error)               got_ev(EV_ERR, 8'h00);
      if (rx_if.eop)                    got_ev(EV_EOP, 8'h00);
      if (!rx_if.rx_active && act_prev) got_ev(EV_FALL, 8'h00);
      act_prev = rx_if.rx_active;
    end
  endtask

  // Line-level packet builder: NRZI encoding with optional bit stuffing.
  task automatic toggle();
    cur = (cur == J) ? K : J;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) lv.push_back(J);
    cur = J;
  endtask

  task automatic add_sync();
    lv.push_back(K); lv.push_back(J); lv.push_back(K); lv.push_back(J);
    lv.push_back(K); lv.push_back(J); lv.push_back(K); lv.push_back(K);
    cur  = K;
    ones = 0;
  endtask

  task automatic add_bit(input logic b, input bit stuff_en);
    if (!b) toggle();
    lv.push_back(cur);
    ones = b ? ones + 1 : 0;
    if (stuff_en && ones == 6) begin
      toggle();
      lv.push_back(cur);
      ones = 0;
    end
  endtask

  task automatic add_bits(input logic [7:0] b, input int n, input bit stuff_en);
    for (int i = 0; i < n; i++) add_bit(b[i], stuff_en);
  endtask

  task automatic add_eop();
    lv.push_back(SE0);
    lv.push_back(SE0);
    add_idle(5);
  endtask

  // act_kind: 0 none, 1 drop enable, 2 pulse rst_n, 3 probe rx_active rise after bit act_bit.
  task automatic send(input bit jit, input int act_bit, input int act_kind, input logic [7:0] last_byte);
    int st[$];
    int pat[4] = '{0, 1, 0, -1};
    int e;
    int jv;
    int n;
    int cyc_act;
    e = 0;
    n = lv.size();
    for (int i = 0; i <= n; i++) begin
      jv = 0;
      if (jit && i > 0 && i < n && lv[i] != lv[i-1]) begin
        jv = pat[e % 4];
        e++;
      end
      st.push_back(OS * i + jv);
    end
    cyc_act = (act_bit >= 0) ? st[act_bit] : -100;
    for (int i = 0; i < n; i++) begin
      for (int c = st[i]; c < st[i+1]; c++) begin
        @(posedge clk);
        #1;
        {dp, dm} = lv[i];
        if (act_kind == 1 && c == cyc_act + 1) enable = 1'b0;
        if (act_kind == 1 && c == cyc_act + 2) begin
          check("en_drop_active", {7'd0, rx_if.rx_active}, 8'h00);
          check("en_drop_valid",  {7'd0, rx_if.rx_valid},  8'h00);
          check("en_drop_error",  {7'd0, rx_if.rx_error},  8'h00);
          check("en_drop_eop",    {7'd0, rx_if.eop},       8'h00);
          check("en_drop_data_hold", rx_if.rx_data, last_byte);
        end
        if (act_kind == 2 && c == cyc_act + 1) begin
          rst_n = 1'b0;
          #1;
          check("rst_mid_active", {7'd0, rx_if.rx_active}, 8'h00);
          check("rst_mid_data",   rx_if.rx_data,           8'h00);
        end
        if (act_kind == 3 && c == cyc_act + 4)
          check("sync_active_pre",  {7'd0, rx_if.rx_active}, 8'h00);
        if (act_kind == 3 && c == cyc_act + 5)
          check("sync_active_rise", {7'd0, rx_if.rx_active}, 8'h01);
      end
    end
    enable = 1'b1;
    rst_n  = 1'b1;
    lv.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clean_packet(input logic [7:0] b, input string name);
    add_idle(4); add_sync(); add_bits(b, 8, 1'b1); add_eop();
    expect_ev(EV_RISE, 8'h00); expect_ev(EV_BYTE, b); expect_ev(EV_EOP, 8'h00); expect_ev(EV_FALL, 8'h00);
    send(1'b0, -1, 0, 8'h00);
    drain(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    cur  = J;
    ones = 0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_active", {7'd0, rx_if.rx_active}, 8'h00);
    check("reset_valid",  {7'd0, rx_if.rx_valid},  8'h00);
    check("reset_error",  {7'd0, rx_if.rx_error},  8'h00);
    check("reset_eop",    {7'd0, rx_if.eop},       8'h00);
    check("reset_data",   rx_if.rx_data,           8'h00);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (8) @(posedge clk);

    // SYNC + A5 + 3C + EOP, with rx_active rise latency probed after the last SYNC K.
    add_idle(4); add_sync(); mark = lv.size() - 1;
    add_bits(8'hA5, 8, 1'b1); add_bits(8'h3C, 8, 1'b1); add_eop();
    expect_ev(EV_RISE, 8'h00); expect_ev(EV_BYTE, 8'hA5); expect_ev(EV_BYTE, 8'h3C);
    expect_ev(EV_EOP, 8'h00);  expect_ev(EV_FALL, 8'h00);
    send(1'b0, mark, 3, 8'h00);
    drain("basic");

    // FF FF with stuff bits inserted.
    add_idle(4); add_sync(); add_bits(8'hFF, 8, 1'b1); add_bits(8'hFF, 8, 1'b1); add_eop();
    expect_ev(EV_RISE, 8'h00); expect_ev(EV_BYTE, 8'hFF); expect_ev(EV_BYTE, 8'hFF);
    expect_ev(EV_EOP, 8'h00);  expect_ev(EV_FALL, 8'h00);
    send(1'b0, -1, 0, 8'h00);
    drain("stuffed");

    // Same payload without stuffing: seventh 1 is a stuff error.
    add_idle(4); add_sync(); add_bits(8'hFF, 8, 1'b0); add_bits(8'hFF, 8, 1'b0); add_eop();
    expect_ev(EV_RISE, 8'h00); expect_ev(EV_ERR, 8'h00); expect_ev(EV_FALL, 8'h00);
    send(1'b0, -1, 0, 8'h00);
    drain("stuff_err");
    clean_packet(8'hC3, "stuff_recover");

    // 0x5A x8 with +/-1 clk edge jitter.
    add_idle(4); add_sync();
    for (int i = 0; i < 8; i++) add_bits(8'h5A, 8, 1'b1);
    add_eop();
    expect_ev(EV_RISE, 8'h00);
    for (int i = 0; i < 8; i++) expect_ev(EV_BYTE, 8'h5A);
    expect_ev(EV_EOP, 8'h00); expect_ev(EV_FALL, 8'h00);
    send(1'b1, -1, 0, 8'h00);
    drain("jitter");

    // SE0 after 4 data bits: partial-byte error, then a valid EOP.
    add_idle(4); add_sync(); add_bits(8'hA5, 4, 1'b1); add_eop();
    expect_ev(EV_RISE, 8'h00); expect_ev(EV_ERR, 8'h00);
    expect_ev(EV_EOP, 8'h00);  expect_ev(EV_FALL, 8'h00);
    send(1'b0, -1, 0, 8'h00);
    drain("short_eop");

    // Single-bit SE0 glitch mid-byte: partial-byte error, then glitch error into ERR.
    add_idle(4); add_sync(); add_bits(8'hA5, 4, 1'b1); lv.push_back(SE0);
    add_bits(8'h0A, 4, 1'b1); add_bits(8'h3C, 8, 1'b1); add_eop();
    expect_ev(EV_RISE, 8'h00); expect_ev(EV_ERR, 8'h00);
    expect_ev(EV_ERR, 8'h00);  expect_ev(EV_FALL, 8'h00);
    send(1'b0, -1, 0, 8'h00);
    drain("glitch");
    clean_packet(8'h96, "glitch_recover");

    // enable dropped in the middle of the second byte.
    add_idle(4); add_sync(); add_bits(8'h11, 8, 1'b1); add_bits(8'h22, 3, 1'b1);
    mark = lv.size();
    add_bits(8'h04, 5, 1'b1); add_eop();
    expect_ev(EV_RISE, 8'h00); expect_ev(EV_BYTE, 8'h11); expect_ev(EV_FALL, 8'h00);
    send(1'b0, mark, 1, 8'h11);
    drain("en_drop");
    clean_packet(8'h3C, "en_recover");

    // rst_n pulsed in the middle of the second byte.
    add_idle(4); add_sync(); add_bits(8'h77, 8, 1'b1); add_bits(8'h88, 3, 1'b1);
    mark = lv.size();
    add_bits(8'h11, 5, 1'b1); add_eop();
    expect_ev(EV_RISE, 8'h00); expect_ev(EV_BYTE, 8'h77); expect_ev(EV_FALL, 8'h00);
    send(1'b0, mark, 2, 8'h00);
    drain("rst_mid");
    clean_packet(8'hE1, "rst_recover");

    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
